// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state encoding.
package serial_add_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle of the bit-serial adder; master issues operands, slave returns the result.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );

endinterface

// File: rtl/adder.sv
// 1-bit full adder: the only arithmetic element of the serial datapath.
module adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);

  assign Sum  = A ^ B ^ Cin;
  assign Cout = (A & B) | (A & Cin) | (B & Cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: adds WIDTH-bit operands LSB first through one full adder,
// one bit per clock, then pulses done with registered sum/cout/ovf held until the next result.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst_n,
  serial_add_ctrl_if.slave bus
);

  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             c_msb;
  logic             fa_sum;
  logic             fa_cout;

  adder u_adder (
    .A    (a_sh_q[0]),
    .B    (b_sh_q[0]),
    .Cin  (carry_q),
    .Sum  (fa_sum),
    .Cout (fa_cout)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    c_msb    = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        // Sum bits enter at the MSB so that after WIDTH shifts the LSB lands at bit 0.
        sum_sh_d           = sum_sh_q >> 1;
        sum_sh_d[WIDTH-1]  = fa_sum;
        a_sh_d             = a_sh_q >> 1;
        b_sh_d             = b_sh_q >> 1;
        carry_d            = fa_cout;
        cnt_d              = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          // carry_q is the carry into the MSB on this last bit-cycle.
          c_msb   = carry_q;
          state_d = ST_DONE;
          sum_d   = sum_sh_d;
          cout_d  = fa_cout;
          ovf_d   = c_msb ^ fa_cout;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.busy = (state_q == ST_RUN);
  assign bus.done = (state_q == ST_DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): vector table, corner sequences, random ops
// compared against a plain-arithmetic reference model.
module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] exp_sum;
    logic       exp_cout;
    logic       exp_ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   compared   = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  serial_add_ctrl_if #(.WIDTH(WIDTH)) bus_if ();

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Reference: full-precision sum; signed overflow when equal-signed operands give a different sign.
  function automatic void refModel(input logic [7:0] a, input logic [7:0] b, input logic cin,
                                   output logic [7:0] s, output logic co, output logic ov);
    logic [8:0] full;
    full = {1'b0, a} + {1'b0, b} + {8'd0, cin};
    s    = full[7:0];
    co   = full[8];
    ov   = (a[7] == b[7]) && (s[7] != a[7]);
  endfunction

  // Issues one operation from a sample point and returns at the sample point of the done cycle.
  // Operand inputs are scrambled during the run to show only latched copies are used.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic cin,
                               output logic [7:0] s, output logic co, output logic ov,
                               output int lat, output int busy_cnt);
    bus_if.start = 1'b1;
    bus_if.a     = a;
    bus_if.b     = b;
    bus_if.cin   = cin;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    lat      = -1;
    busy_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus_if.done) begin
        lat = k;
        break;
      end
      if (bus_if.busy) busy_cnt++;
      bus_if.a   = 8'($urandom);
      bus_if.b   = 8'($urandom);
      bus_if.cin = 1'($urandom);
      @(posedge clk); #1;
    end
    s  = bus_if.sum;
    co = bus_if.cout;
    ov = bus_if.ovf;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    vec_t       vecs[7];
    logic [7:0] s, es;
    logic       co, ov, eco, eov;
    int         lat, bcnt, dcnt, first_done;
    int         done_at[$];

    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};

    rst_n        = 1'b0;
    bus_if.start = 1'b0;
    bus_if.a     = '0;
    bus_if.b     = '0;
    bus_if.cin   = 1'b0;
    #12;
    checkOutput("reset_busy", 32'(bus_if.busy), 32'd0);
    checkOutput("reset_done", 32'(bus_if.done), 32'd0);
    checkOutput("reset_sum",  32'(bus_if.sum),  32'd0);
    checkOutput("reset_cout", 32'(bus_if.cout), 32'd0);
    checkOutput("reset_ovf",  32'(bus_if.ovf),  32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table vectors; consecutive entries start in the DONE cycle of the previous one.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, s, co, ov, lat, bcnt);
      checkOutput($sformatf("vec%0d_sum", i),  32'(s),  32'(vecs[i].exp_sum));
      checkOutput($sformatf("vec%0d_cout", i), 32'(co), 32'(vecs[i].exp_cout));
      checkOutput($sformatf("vec%0d_ovf", i),  32'(ov), 32'(vecs[i].exp_ovf));
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'(WIDTH));
      checkOutput($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 32'(WIDTH));
    end

    // Result must hold through IDLE.
    idleCycles(4);
    checkOutput("hold_sum",  32'(bus_if.sum),  32'h80);
    checkOutput("hold_ovf",  32'(bus_if.ovf),  32'd1);
    checkOutput("hold_done", 32'(bus_if.done), 32'd0);

    // A start pulse during RUN is ignored.
    bus_if.start = 1'b1; bus_if.a = 8'h12; bus_if.b = 8'h34; bus_if.cin = 1'b0;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    dcnt = 0; first_done = -1; s = '0;
    for (int k = 0; k < 24; k++) begin
      if (k == 2) begin
        bus_if.start = 1'b1; bus_if.a = 8'hFF; bus_if.b = 8'hFF;
      end else begin
        bus_if.start = 1'b0;
      end
      if (bus_if.done) begin
        dcnt++;
        if (first_done < 0) begin
          first_done = k;
          s = bus_if.sum;
        end
      end
      @(posedge clk); #1;
    end
    checkOutput("busy_start_sum", 32'(s), 32'h46);
    checkOutput("busy_start_latency", 32'(first_done), 32'(WIDTH));
    checkOutput("busy_start_done_count", 32'(dcnt), 32'd1);

    // Async reset in the middle of a run.
    applyStimulus(8'h7F, 8'h01, 1'b0, s, co, ov, lat, bcnt);
    checkOutput("pre_reset_sum", 32'(s), 32'h80);
    bus_if.start = 1'b1; bus_if.a = 8'h55; bus_if.b = 8'hAA; bus_if.cin = 1'b1;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    idleCycles(3);
    rst_n = 1'b0;
    #1;
    checkOutput("midrun_reset_busy", 32'(bus_if.busy), 32'd0);
    checkOutput("midrun_reset_done", 32'(bus_if.done), 32'd0);
    checkOutput("midrun_reset_sum",  32'(bus_if.sum),  32'd0);
    checkOutput("midrun_reset_cout", 32'(bus_if.cout), 32'd0);
    checkOutput("midrun_reset_ovf",  32'(bus_if.ovf),  32'd0);
    idleCycles(2);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    dcnt = 0; bcnt = 0;
    for (int k = 0; k < 12; k++) begin
      if (bus_if.done) dcnt++;
      if (bus_if.busy) bcnt++;
      @(posedge clk); #1;
    end
    checkOutput("post_reset_no_done", 32'(dcnt), 32'd0);
    checkOutput("post_reset_no_busy", 32'(bcnt), 32'd0);
    applyStimulus(8'h05, 8'h03, 1'b0, s, co, ov, lat, bcnt);
    checkOutput("post_reset_sum", 32'(s), 32'h08);
    checkOutput("post_reset_latency", 32'(lat), 32'(WIDTH));

    // Start held high: back-to-back operations, one done each, busy right after each done.
    idleCycles(2);
    bus_if.start = 1'b1; bus_if.a = 8'hA5; bus_if.b = 8'h5A; bus_if.cin = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 30; k++) begin
      if (bus_if.done) begin
        done_at.push_back(k);
        checkOutput($sformatf("held_sum_k%0d", k),  32'(bus_if.sum),  32'h00);
        checkOutput($sformatf("held_cout_k%0d", k), 32'(bus_if.cout), 32'd1);
        checkOutput($sformatf("held_ovf_k%0d", k),  32'(bus_if.ovf),  32'd0);
        checkOutput($sformatf("held_busy_in_done_k%0d", k), 32'(bus_if.busy), 32'd0);
        @(posedge clk); #1;
        checkOutput($sformatf("held_busy_after_done_k%0d", k), 32'(bus_if.busy), 32'd1);
        k++;
      end
      @(posedge clk); #1;
    end
    bus_if.start = 1'b0;
    checkOutput("held_done_count", 32'(done_at.size()), 32'd3);
    for (int i = 0; i < done_at.size(); i++)
      checkOutput($sformatf("held_done_pos%0d", i), 32'(done_at[i]), 32'(WIDTH + i * (WIDTH + 1)));
    for (int k = 0; k < 20; k++) begin
      if (bus_if.done) break;
      @(posedge clk); #1;
    end
    checkOutput("held_drain_done", 32'(bus_if.done), 32'd1);

    // Random operations against the reference model, with occasional idle gaps.
    for (int n = 0; n < 1500; n++) begin
      logic [7:0] ra, rb;
      logic       rc;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      if ($urandom_range(0, 3) == 0) idleCycles(int'($urandom_range(1, 3)));
      applyStimulus(ra, rb, rc, s, co, ov, lat, bcnt);
      refModel(ra, rb, rc, es, eco, eov);
      checkOutput($sformatf("rnd%0d_sum %h+%h+%b", n, ra, rb, rc), 32'(s), 32'(es));
      checkOutput($sformatf("rnd%0d_cout", n), 32'(co), 32'(eco));
      checkOutput($sformatf("rnd%0d_ovf", n),  32'(ov), 32'(eov));
      checkOutput($sformatf("rnd%0d_latency", n), 32'(lat), 32'(WIDTH));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
